// File: rtl/lc3_ctrl_fsm.sv
// LC-3 control sequencer: registered state, registered BEN, bounded memory waits
// with sticky timeout, interrupt acknowledge at fetch and illegal-opcode trapping.
module lc3_ctrl_fsm #(
   parameter int MEM_WAIT_MAX = 15,
   parameter bit INT_ENABLE   = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] ir,
   input  logic [2:0]  nzp,
   input  logic        mem_r,
   input  logic        intr_req,
   output logic [5:0]  state,
   output logic        ben,
   output logic [2:0]  dr,
   output logic [2:0]  sr1,
   output logic        ld_mar,
   output logic        ld_mdr,
   output logic        ld_ir,
   output logic        ld_pc,
   output logic        ld_ben,
   output logic        ld_reg,
   output logic        ld_cc,
   output logic        mem_en,
   output logic        mem_we,
   output logic        int_ack,
   output logic        illegal_op,
   output logic        mem_timeout
);

   typedef enum logic [5:0] {
      S0  = 6'd0,  S1  = 6'd1,  S2  = 6'd2,  S3  = 6'd3,  S4  = 6'd4,
      S5  = 6'd5,  S6  = 6'd6,  S7  = 6'd7,  S8  = 6'd8,  S9  = 6'd9,
      S10 = 6'd10, S11 = 6'd11, S12 = 6'd12, S13 = 6'd13, S14 = 6'd14,
      S15 = 6'd15, S16 = 6'd16, S18 = 6'd18, S20 = 6'd20, S21 = 6'd21,
      S22 = 6'd22, S23 = 6'd23, S24 = 6'd24, S25 = 6'd25, S26 = 6'd26,
      S27 = 6'd27, S28 = 6'd28, S29 = 6'd29, S30 = 6'd30, S31 = 6'd31,
      S32 = 6'd32, S33 = 6'd33, S35 = 6'd35, S49 = 6'd49, RST = 6'd63
   } state_t;

   localparam int CW = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q;
   logic          ben_q;
   logic          tout_q;
   logic          is_wait;
   logic          expire;
   logic          abort;

   always_comb begin
      unique case (state_q)
         S33, S28, S25, S24, S29, S16: is_wait = 1'b1;
         default:                      is_wait = 1'b0;
      endcase
   end

   // Expiry fires on the MEM_WAIT_MAX-th consecutive mem_r-low cycle; mem_r high wins.
   assign expire = (MEM_WAIT_MAX != 0) && !mem_r && ((int'(cnt_q) + 1) == MEM_WAIT_MAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RST;
         cnt_q   <= '0;
         ben_q   <= 1'b0;
         tout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (is_wait && state_d == state_q)
            cnt_q <= cnt_q + 1'b1;
         else
            cnt_q <= '0;
         if (state_q == S32)
            ben_q <= (ir[11] & nzp[2]) | (ir[10] & nzp[1]) | (ir[9] & nzp[0]);
         if (abort)
            tout_q <= 1'b1;
      end
   end

   always_comb begin
      state_d = S18;
      abort   = 1'b0;
      if (is_wait && !mem_r) begin
         if (expire) begin
            state_d = S18;
            abort   = 1'b1;
         end else begin
            state_d = state_q;
         end
      end else begin
         unique case (state_q)
            RST:  state_d = S18;
            S18:  state_d = (INT_ENABLE && intr_req) ? S49 : S33;
            S33:  state_d = S35;
            S35:  state_d = S32;
            S32:  state_d = state_t'({2'b00, ir[15:12]});
            S15:  state_d = S28;
            S28:  state_d = S30;
            S2, S6: state_d = S25;
            S25:  state_d = S27;
            S10:  state_d = S24;
            S24:  state_d = S26;
            S26:  state_d = S25;
            S11:  state_d = S29;
            S29:  state_d = S31;
            S31, S3, S7: state_d = S23;
            S23:  state_d = S16;
            S16:  state_d = S18;
            S4:   state_d = ir[11] ? S21 : S20;
            S0:   state_d = ben_q ? S22 : S18;
            default: state_d = S18;
         endcase
      end
   end

   always_comb begin
      ld_mar     = 1'b0;
      ld_mdr     = 1'b0;
      ld_ir      = 1'b0;
      ld_pc      = 1'b0;
      ld_ben     = 1'b0;
      ld_reg     = 1'b0;
      ld_cc      = 1'b0;
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      int_ack    = 1'b0;
      illegal_op = 1'b0;
      unique case (state_q)
         S18: begin ld_mar = 1'b1; ld_pc = 1'b1; end
         S33, S25, S24, S29: begin mem_en = 1'b1; ld_mdr = 1'b1; end
         S28: begin mem_en = 1'b1; ld_mdr = 1'b1; ld_reg = 1'b1; end
         S16: begin mem_en = 1'b1; mem_we = 1'b1; end
         S35: ld_ir = 1'b1;
         S32: ld_ben = 1'b1;
         S2, S6, S7, S3, S10, S11, S26, S15: ld_mar = 1'b1;
         S1, S5, S9, S14, S27: begin ld_reg = 1'b1; ld_cc = 1'b1; end
         S20, S21: begin ld_reg = 1'b1; ld_pc = 1'b1; end
         S30, S22, S12: ld_pc = 1'b1;
         S23: ld_mdr = 1'b1;
         S49: int_ack = 1'b1;
         S8, S13: illegal_op = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      unique case (state_q)
         S4, S20, S21, S28: dr = 3'b111;
         default:           dr = ir[11:9];
      endcase
      sr1 = (state_q == S23) ? ir[11:9] : ir[8:6];
   end

   assign state       = state_q;
   assign ben         = ben_q;
   assign mem_timeout = tout_q;

endmodule

// File: tb/tb_lc3_ctrl_fsm.sv
// Directed bench for lc3_ctrl_fsm: fetch/execute flows, wait/timeout, BEN,
// interrupt and illegal-opcode handling, asynchronous reset.
module tb_lc3_ctrl_fsm;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] ir = '0;
   logic [2:0]  nzp = '0;
   logic        mem_r = 1'b1;
   logic        intr_req = 1'b0;

   logic [5:0] state;
   logic       ben, ld_mar, ld_mdr, ld_ir, ld_pc, ld_ben, ld_reg, ld_cc;
   logic       mem_en, mem_we, int_ack, illegal_op, mem_timeout;
   logic [2:0] dr, sr1;

   logic [5:0] state_b;
   logic       ben_b, ld_mar_b, ld_mdr_b, ld_ir_b, ld_pc_b, ld_ben_b, ld_reg_b, ld_cc_b;
   logic       mem_en_b, mem_we_b, int_ack_b, illegal_op_b, mem_timeout_b;
   logic [2:0] dr_b, sr1_b;

   logic [10:0] strobes;
   assign strobes = {ld_mar, ld_mdr, ld_ir, ld_pc, ld_ben, ld_reg, ld_cc,
                     mem_en, mem_we, int_ack, illegal_op};

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   lc3_ctrl_fsm #(.MEM_WAIT_MAX(4), .INT_ENABLE(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .ir(ir), .nzp(nzp), .mem_r(mem_r), .intr_req(intr_req),
      .state(state), .ben(ben), .dr(dr), .sr1(sr1),
      .ld_mar(ld_mar), .ld_mdr(ld_mdr), .ld_ir(ld_ir), .ld_pc(ld_pc), .ld_ben(ld_ben),
      .ld_reg(ld_reg), .ld_cc(ld_cc), .mem_en(mem_en), .mem_we(mem_we),
      .int_ack(int_ack), .illegal_op(illegal_op), .mem_timeout(mem_timeout));

   lc3_ctrl_fsm #(.MEM_WAIT_MAX(15), .INT_ENABLE(1'b0)) dut_noint (
      .clk(clk), .rst_n(rst_n), .ir(ir), .nzp(nzp), .mem_r(mem_r), .intr_req(intr_req),
      .state(state_b), .ben(ben_b), .dr(dr_b), .sr1(sr1_b),
      .ld_mar(ld_mar_b), .ld_mdr(ld_mdr_b), .ld_ir(ld_ir_b), .ld_pc(ld_pc_b), .ld_ben(ld_ben_b),
      .ld_reg(ld_reg_b), .ld_cc(ld_cc_b), .mem_en(mem_en_b), .mem_we(mem_we_b),
      .int_ack(int_ack_b), .illegal_op(illegal_op_b), .mem_timeout(mem_timeout_b));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n    = 1'b0;
      mem_r    = 1'b1;
      intr_req = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      ir = 16'h1042;
      do_reset();
      checks++;
      if (state !== 6'd63) begin errors++; $display("FAIL reset_state got=%0d exp=63", state); end
      checks++;
      if (strobes !== 11'b0) begin errors++; $display("FAIL reset_strobes got=%b exp=0", strobes); end
      checks++;
      if (ben !== 1'b0 || mem_timeout !== 1'b0) begin
         errors++; $display("FAIL reset_flags got ben=%b tout=%b exp 0 0", ben, mem_timeout);
      end
   endtask

   task automatic test_add();
      int exp_s[6] = '{18, 33, 35, 32, 1, 18};
      ir = 16'h1042;
      for (int i = 0; i < 6; i++) begin
         step();
         checks++;
         if (state !== 6'(exp_s[i])) begin errors++; $display("FAIL add_seq[%0d] got=%0d exp=%0d", i, state, exp_s[i]); end
         if (exp_s[i] == 18 && i == 0) begin
            checks++;
            if (ld_mar !== 1'b1 || ld_pc !== 1'b1) begin errors++; $display("FAIL fetch_strobes got mar=%b pc=%b exp 1 1", ld_mar, ld_pc); end
         end
         if (exp_s[i] == 1) begin
            checks++;
            if ({ld_reg, ld_cc} !== 2'b11) begin errors++; $display("FAIL add_ld got=%b exp=11", {ld_reg, ld_cc}); end
            checks++;
            if (dr !== 3'd0 || sr1 !== 3'd1) begin errors++; $display("FAIL add_regs got dr=%0d sr1=%0d exp 0 1", dr, sr1); end
         end
      end
   endtask

   task automatic test_ldr_wait();
      int exp_s[5] = '{33, 35, 32, 6, 25};
      ir    = 16'h6281;
      mem_r = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (state !== 6'(exp_s[i])) begin errors++; $display("FAIL ldr_seq[%0d] got=%0d exp=%0d", i, state, exp_s[i]); end
      end
      mem_r = 1'b0;
      checks++;
      if (mem_en !== 1'b1 || ld_mdr !== 1'b1) begin errors++; $display("FAIL ldr_rd_strobes got en=%b mdr=%b exp 1 1", mem_en, ld_mdr); end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (state !== 6'd25) begin errors++; $display("FAIL ldr_hold[%0d] got=%0d exp=25", i, state); end
      end
      mem_r = 1'b1;
      step();
      checks++;
      if (state !== 6'd27) begin errors++; $display("FAIL ldr_exit got=%0d exp=27", state); end
      checks++;
      if ({ld_reg, ld_cc} !== 2'b11) begin errors++; $display("FAIL ldr_ld got=%b exp=11", {ld_reg, ld_cc}); end
      checks++;
      if (mem_timeout !== 1'b0) begin errors++; $display("FAIL ldr_tout got=%b exp=0", mem_timeout); end
      step();
      checks++;
      if (state !== 6'd18) begin errors++; $display("FAIL ldr_done got=%0d exp=18", state); end
   endtask

   task automatic test_timeout();
      mem_r = 1'b0;
      step();
      checks++;
      if (state !== 6'd33) begin errors++; $display("FAIL tout_enter got=%0d exp=33", state); end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (state !== 6'd33 || mem_timeout !== 1'b0) begin
            errors++; $display("FAIL tout_hold[%0d] got st=%0d tout=%b exp 33 0", i, state, mem_timeout);
         end
      end
      step();
      checks++;
      if (state !== 6'd18) begin errors++; $display("FAIL tout_abort got=%0d exp=18", state); end
      checks++;
      if (mem_timeout !== 1'b1) begin errors++; $display("FAIL tout_set got=%b exp=1", mem_timeout); end
      mem_r = 1'b1;
      ir    = 16'h1042;
      repeat (5) step();
      checks++;
      if (state !== 6'd18 || mem_timeout !== 1'b1) begin
         errors++; $display("FAIL tout_sticky got st=%0d tout=%b exp 18 1", state, mem_timeout);
      end
   endtask

   task automatic test_reset_mid_wait();
      int exp_s[6] = '{33, 35, 32, 3, 23, 16};
      ir = 16'h3A00;
      for (int i = 0; i < 6; i++) begin
         step();
         checks++;
         if (state !== 6'(exp_s[i])) begin errors++; $display("FAIL st_seq[%0d] got=%0d exp=%0d", i, state, exp_s[i]); end
         if (exp_s[i] == 23) begin
            checks++;
            if (ld_mdr !== 1'b1 || sr1 !== 3'd5) begin errors++; $display("FAIL st_23 got mdr=%b sr1=%0d exp 1 5", ld_mdr, sr1); end
            mem_r = 1'b0;
         end
      end
      step();
      checks++;
      if (state !== 6'd16 || mem_en !== 1'b1 || mem_we !== 1'b1) begin
         errors++; $display("FAIL st_wr got st=%0d en=%b we=%b exp 16 1 1", state, mem_en, mem_we);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (state !== 6'd63 || strobes !== 11'b0) begin
         errors++; $display("FAIL async_reset got st=%0d strobes=%b exp 63 0", state, strobes);
      end
      checks++;
      if (mem_timeout !== 1'b0) begin errors++; $display("FAIL async_tout got=%b exp=0", mem_timeout); end
      mem_r = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_branch();
      int exp_s[6] = '{18, 33, 35, 32, 0, 22};
      ir  = 16'h0405;
      nzp = 3'b010;
      for (int i = 0; i < 6; i++) begin
         step();
         checks++;
         if (state !== 6'(exp_s[i])) begin errors++; $display("FAIL brt_seq[%0d] got=%0d exp=%0d", i, state, exp_s[i]); end
      end
      checks++;
      if (ben !== 1'b1 || ld_pc !== 1'b1) begin errors++; $display("FAIL brt_22 got ben=%b pc=%b exp 1 1", ben, ld_pc); end
      nzp = 3'b100;
      for (int i = 0; i < 5; i++) step();
      checks++;
      if (state !== 6'd0 || ben !== 1'b0) begin errors++; $display("FAIL brn_0 got st=%0d ben=%b exp 0 0", state, ben); end
      step();
      checks++;
      if (state !== 6'd18) begin errors++; $display("FAIL brn_exit got=%0d exp=18", state); end
   endtask

   task automatic test_interrupt();
      ir = 16'h1042;
      do_reset();
      step();
      checks++;
      if (state !== 6'd18 || state_b !== 6'd18) begin errors++; $display("FAIL int_start got a=%0d b=%0d exp 18 18", state, state_b); end
      intr_req = 1'b1;
      step();
      checks++;
      if (state !== 6'd49 || int_ack !== 1'b1) begin errors++; $display("FAIL int_ack got st=%0d ack=%b exp 49 1", state, int_ack); end
      checks++;
      if (state_b !== 6'd33 || int_ack_b !== 1'b0) begin errors++; $display("FAIL noint got st=%0d ack=%b exp 33 0", state_b, int_ack_b); end
      intr_req = 1'b0;
      step();
      checks++;
      if (state !== 6'd18 || int_ack !== 1'b0) begin errors++; $display("FAIL int_done got st=%0d ack=%b exp 18 0", state, int_ack); end
      checks++;
      if (state_b !== 6'd35 || int_ack_b !== 1'b0) begin errors++; $display("FAIL noint_next got st=%0d ack=%b exp 35 0", state_b, int_ack_b); end
   endtask

   task automatic test_illegal();
      int exp_s[5] = '{33, 35, 32, 13, 18};
      ir = 16'hD000;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (state !== 6'(exp_s[i])) begin errors++; $display("FAIL ill_seq[%0d] got=%0d exp=%0d", i, state, exp_s[i]); end
         checks++;
         if (illegal_op !== (exp_s[i] == 13)) begin
            errors++; $display("FAIL ill_pulse[%0d] got=%b exp=%b", i, illegal_op, exp_s[i] == 13);
         end
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_ldr_wait();
      test_timeout();
      test_reset_mid_wait();
      test_branch();
      test_interrupt();
      test_illegal();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/lc3_ctrl_fsm.md
# lc3_ctrl_fsm

Parametrised LC-3 control state machine: the next-generation instruction sequencer, driving datapath load strobes, memory strobes and register-select fields from a registered state. Compared with the first-generation sequencer it adds a registered BEN, a bounded memory-wait timeout with abort, interrupt acknowledge at fetch, illegal-opcode trapping (RTI/reserved), and a dedicated post-reset state. It sits between the instruction register/condition codes and the datapath and memory interface.

## Interface
- MEM_WAIT_MAX, 15: cycles allowed in a memory wait state without `mem_r` before abort; 0 disables the timeout.
- INT_ENABLE, 1: 1 enables the interrupt branch at fetch; 0 ignores `intr_req`.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ir  in  16  current instruction register.
- nzp  in  3  condition codes {N,Z,P}.
- mem_r  in  1  memory ready, sampled in wait states.
- intr_req  in  1  level interrupt request.
- state  out  6  current state code.
- ben  out  1  registered branch enable.
- dr  out  3  destination register select.
- sr1  out  3  source-1 register select.
- ld_mar, ld_mdr, ld_ir, ld_pc, ld_ben, ld_reg, ld_cc  out  1 each  datapath load strobes.
- mem_en, mem_we  out  1 each  memory enable / write.
- int_ack  out  1  one-cycle interrupt acknowledge.
- illegal_op  out  1  one-cycle pulse on RTI (opcode 8) or reserved (opcode 13).
- mem_timeout  out  1  sticky; set on any wait abort, cleared only by reset.

## Operation
- States use the standard LC-3 numbering; extra RST=63.
- Transitions: RST→18; 18→49 if INT_ENABLE&&intr_req else 33; 33→35 on mem_r; 35→32; 32→ir[15:12]; 1,5,9,12,14,21,20,22,27,30→18; 49→18; 8,13→18; 15→28; 28→30 on mem_r; 2,6→25; 25→27 on mem_r; 10→24; 24→26 on mem_r; 26→25; 11→29; 29→31 on mem_r; 31,3,7→23; 23→16; 16→18 on mem_r; 4→21 if ir[11] else 20; 0→22 if ben else 18.
- Wait states (33,28,25,24,29,16): hold while mem_r=0. Wait counter clears on entry and counts cycles with mem_r=0; when MEM_WAIT_MAX≠0 and counter reaches MEM_WAIT_MAX, next state is 18 and mem_timeout sets. mem_r in the same cycle as expiry wins (normal exit).
- Any undefined state code → 18.
- ben: loaded in state 32 with (ir[11]&N)|(ir[10]&Z)|(ir[9]&P); held otherwise; reset 0.
- Moore strobes (combinational from state): ld_mar,ld_pc in 18; mem_en,ld_mdr in 33,28,25,24,29; mem_en,mem_we in 16; ld_ir in 35; ld_ben in 32; ld_mar in 2,6,7,3,10,11,26,15; ld_reg,ld_cc in 1,5,9,14,27; ld_reg in 28,20,21; ld_pc in 30,20,21,22,12; ld_mdr in 23; int_ack in 49; illegal_op in 8,13. All zero in RST.
- dr = 3'b111 in 4,20,21,28; else ir[11:9]. sr1 = ir[11:9] in 23; else ir[8:6].

## Timing
- Reset: state=RST, ben=0, counter=0, mem_timeout=0; all strobes 0. First rising edge after release enters 18.
- Fetch with zero-wait memory (mem_r high): 18,33,35,32 then execute; ADD occupies 5 cycles total (18,33,35,32,1).
- Each wait state adds one cycle per mem_r-low cycle, up to MEM_WAIT_MAX.
- intr_req sampled only in 18; int_ack is exactly one cycle.
- Reset assertion mid-wait returns to RST immediately (asynchronous); mem_timeout cleared.

## Test plan
- ADD (ir=16'h1042), mem_r=1 -> states 63,18,33,35,32,1,18; ld_reg&ld_cc high in state 1; dr=0, sr1=1.
- LDR (ir=16'h6281), mem_r low 3 cycles in 25 -> 25 held 4 cycles, then 27 with ld_reg,ld_cc; mem_timeout=0.
- MEM_WAIT_MAX=4, mem_r=0 in 33 -> after 4 cycles state 18, mem_timeout=1 and stays 1 through later instructions.
- BRz (ir=16'h0405), nzp=3'b010 -> ben=1, 0→22 with ld_pc; nzp=3'b100 -> 0→18, no ld_pc.
- intr_req=1 at state 18 -> 49 with int_ack one cycle, then 18; INT_ENABLE=0 -> 33, int_ack never high.
- ir=16'hD000 -> state 13, illegal_op pulse, then 18; rst_n low during 16 -> state 63, all strobes 0 same cycle.
